stack_master: RTL

- Initiator for the 8-deep byte stack (`inclass` datapath). The stack's `logic_blk` is the responder.
- Converts a client-side push/pop request/acknowledge interface into well-formed single-cycle `write`/`read` strobes.
- Tracks occupancy locally, so the stack is never overflowed or underflowed.
- Returns popped bytes to the client with a valid strobe.

---
 rtl/stack_master.sv | 128 ++++++++++++
 1 files changed

// File: rtl/stack_master.sv
// Initiator for the byte stack: turns client push/pop handshakes into single-cycle
// write/read strobes and tracks occupancy locally so the stack never over/underflows.
module stack_master #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int RD_LAT = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_req,
    input  logic [DATA_W-1:0]          push_data,
    output logic                       push_ack,
    input  logic                       pop_req,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       pop_valid,
    output logic                       write,
    output logic                       read,
    output logic [DATA_W-1:0]          data_in,
    input  logic [DATA_W-1:0]          data_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       error
);

    // state | meaning
    // IDLE  | arbitrate requests, pop first
    // PUSH  | write strobe + push_ack
    // GAP   | mandatory low cycle after a write
    // POP   | read strobe
    // WAIT  | wait RD_LAT cycles for data_out
    // DONE  | pop_valid pulse, doubles as inter-strobe gap
    typedef enum logic [2:0] {IDLE, PUSH, GAP, POP, WAIT, DONE} state_t;

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = 2;

    state_t              r_state;
    logic [CNT_W-1:0]    r_count;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [DATA_W-1:0]   r_pop_data;
    logic [DATA_W-1:0]   r_data_in;
    logic                r_write;
    logic                r_read;
    logic                r_push_ack;
    logic                r_pop_valid;
    logic                r_error;
    logic                w_full;
    logic                w_empty;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_wait_cnt  <= '0;
            r_pop_data  <= '0;
            r_data_in   <= '0;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_push_ack  <= 1'b0;
            r_pop_valid <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_push_ack  <= 1'b0;
            r_pop_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (pop_req && !w_empty) begin
                        r_state <= POP;
                        r_read  <= 1'b1;
                    end else if (push_req && !w_full) begin
                        r_state    <= PUSH;
                        r_write    <= 1'b1;
                        r_push_ack <= 1'b1;
                        r_data_in  <= push_data;
                    end else if (pop_req || push_req) begin
                        r_error <= 1'b1;
                    end
                end
                PUSH: begin
                    r_count <= r_count + CNT_W'(1);
                    r_state <= GAP;
                end
                GAP: r_state <= IDLE;
                POP: begin
                    r_count <= r_count - CNT_W'(1);
                    if (RD_LAT == 0) begin
                        r_pop_data  <= data_out;
                        r_pop_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_wait_cnt <= WAIT_W'(RD_LAT - 1);
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    // Sample on the last WAIT edge, RD_LAT cycles after read.
                    if (r_wait_cnt == '0) begin
                        r_pop_data  <= data_out;
                        r_pop_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign write     = r_write;
    assign read      = r_read;
    assign push_ack  = r_push_ack;
    assign pop_valid = r_pop_valid;
    assign pop_data  = r_pop_data;
    assign data_in   = r_data_in;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign error     = r_error;

endmodule
